// File: rtl/store_retire_buffer.sv
// In-order speculative store buffer: stores enter tagged with an instruction ID,
// commit on matching retirement, drain to the d-cache in program order.
module store_retire_buffer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_valid,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  input  logic [DATA_WIDTH-1:0]        alloc_data,
  input  logic [ID_WIDTH-1:0]          alloc_id,
  output logic                         alloc_ready,
  input  logic                         retire_valid,
  input  logic [ID_WIDTH-1:0]          retire_id,
  input  logic                         squash,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr,
  output logic                         lookup_hit,
  output logic [DATA_WIDTH-1:0]        lookup_data,
  output logic                         drain_valid,
  output logic [ADDR_WIDTH-1:0]        drain_addr,
  output logic [DATA_WIDTH-1:0]        drain_data,
  input  logic                         drain_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(DEPTH+1);

  typedef logic [PW-1:0] ptr_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } ent_t;

  ent_t [DEPTH-1:0] ent_q;
  ptr_t head_q, commit_q, tail_q;
  ptr_t head_d, commit_d, tail_d;
  ptr_t occ;
  logic alloc_fire, commit_hit, drain_fire;
  logic [IW-1:0] idx;

  assign occ         = tail_q - head_q;
  assign count       = CW'(occ);
  assign empty       = (head_q == tail_q);
  assign full        = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
  assign alloc_ready = !full;
  assign drain_valid = (head_q != commit_q);
  assign drain_addr  = drain_valid ? ent_q[head_q[IW-1:0]].addr : '0;
  assign drain_data  = drain_valid ? ent_q[head_q[IW-1:0]].data : '0;

  assign alloc_fire = alloc_valid && !full && !squash;
  assign drain_fire = drain_valid && drain_ready;
  assign commit_hit = retire_valid && (commit_q != tail_q) &&
                      (ent_q[commit_q[IW-1:0]].id == retire_id);

  // Squash rolls tail back to the post-retire commit point so a same-cycle
  // commit survives.
  always_comb begin
    head_d   = head_q + ptr_t'(drain_fire);
    commit_d = commit_q + ptr_t'(commit_hit);
    tail_d   = squash ? commit_d : tail_q + ptr_t'(alloc_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && alloc_fire)
      ent_q[tail_q[IW-1:0]] <= '{addr: alloc_addr, data: alloc_data, id: alloc_id};
  end

  // Oldest-to-youngest walk; later matches overwrite, so the youngest wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q[IW-1:0] + IW'(i);
      if ((ptr_t'(i) < occ) && (ent_q[idx].addr == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = ent_q[idx].data;
      end
    end
  end
endmodule

// File: doc/store_retire_buffer.md
Name: store_retire_buffer

Overview:
- Parametrised, in-order store buffer between the MEM-stage store path and the d-cache write port.
- Stores enter speculatively, tagged with their instruction ID. They become committed when the retirement interface reports the same ID, and only committed stores drain to the d-cache.
- New versus the fixed single-purpose write buffer: configurable depth/width, explicit commit pointer, squash of uncommitted stores, youngest-match store-to-load forwarding, valid/ready drain handshake.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- ADDR_WIDTH, 26, byte address width.
- DATA_WIDTH, 32, store data width; word stores only.
- ID_WIDTH, 20, instruction ID width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- alloc_valid  input  1  a store is presented for allocation.
- alloc_addr  input  ADDR_WIDTH  store address.
- alloc_data  input  DATA_WIDTH  store data.
- alloc_id  input  ID_WIDTH  store instruction ID.
- alloc_ready  output  1  buffer can accept a store this cycle.
- retire_valid  input  1  an instruction retires this cycle.
- retire_id  input  ID_WIDTH  ID of the retiring instruction.
- squash  input  1  discard all uncommitted entries.
- lookup_addr  input  ADDR_WIDTH  load address to check for forwarding.
- lookup_hit  output  1  a valid entry matches lookup_addr.
- lookup_data  output  DATA_WIDTH  data of the youngest matching entry.
- drain_valid  output  1  head entry is committed and offered to the d-cache.
- drain_addr  output  ADDR_WIDTH  head entry address.
- drain_data  output  DATA_WIDTH  head entry data.
- drain_ready  input  1  d-cache accepts the drain this cycle.
- count  output  $clog2(DEPTH+1)  number of occupied entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage: circular array of DEPTH entries {addr, data, id}.
  - Pointers head, commit, tail are each $clog2(DEPTH)+1 bits; the extra MSB is a wrap bit.
  - Occupied range is [head, tail). Committed range is [head, commit). Invariant: head <= commit <= tail in modular order.
- Reset (rst_n low at posedge clk):
  - head = commit = tail = 0, so count=0, empty=1, full=0.
  - alloc_ready=1, drain_valid=0, lookup_hit=0. drain_addr, drain_data and lookup_data read 0 while no entry drives them.
  - Reset mid-operation drops all entries, committed or not.
- Allocate:
  - alloc_ready = !full. Registered-state only; it does not depend on same-cycle drain or squash.
  - On alloc_valid && alloc_ready && !squash: write the entry at tail, then tail++.
  - alloc_valid while full is ignored; upstream stalls.
- Commit:
  - On retire_valid, compare retire_id with the id of the entry at commit, provided commit != tail.
  - On a match, commit++. Otherwise no effect; non-store retirements are expected and ignored.
  - At most one commit per cycle.
- Squash:
  - tail <= commit after this cycle's commit update.
  - A same-cycle retire that commits an entry therefore keeps that entry.
  - Allocation in a squash cycle is dropped.
  - Committed entries are never discarded.
- Drain:
  - drain_valid = (head != commit). drain_addr and drain_data come from the head entry and are held stable while drain_valid && !drain_ready.
  - On drain_valid && drain_ready: head++. Drains are in program order, one per cycle.
- Simultaneous events:
  - Alloc, retire and drain may all complete in one cycle.
  - count next = count + alloc_fire - drain_fire, or, on squash, (commit_next - head_next).
- Forwarding (combinational on registered state):
  - Scan entries from tail-1 back to head; the first entry with addr == lookup_addr wins.
  - Committed and uncommitted entries are both eligible. The head entry being drained this cycle is still eligible.
  - A store allocated in the same cycle is not visible to lookup.
  - No match: lookup_hit=0, lookup_data=0.
- Wrap-around:
  - Pointers wrap modulo 2*DEPTH.
  - full when the index bits are equal and the wrap bits differ; empty when all bits are equal.
  - The same applies between commit and head for drain_valid.

Test Plan:
- Reset, then alloc (0x100,0xAAAA0001,id 5), (0x104,0xBBBB0002,id 6); retire id 5 -> drain_valid=1 with addr 0x100 next cycle, id 6 not offered; drain_ready=1 -> count=1, drain_valid=0.
- Alloc 0x200/0x11 id 1, then 0x200/0x22 id 2; lookup_addr=0x200 -> lookup_hit=1, lookup_data=0x22; lookup 0x204 -> hit=0, data=0.
- Alloc ids 10, 11, 12; retire 10; squash in the same cycle as retire 11 -> ids 10 and 11 remain (count=2), id 12 gone, lookup of id 12's address misses.
- DEPTH=8: alloc 8 stores without retiring -> full=1, alloc_ready=0; a 9th alloc_valid is ignored and count stays 8.
- Continuously alloc/retire/drain 20 stores with drain_ready toggled 1/0 -> d-cache sees all 20 addresses in order, none duplicated; drain_addr is stable during stall cycles; pointers wrap cleanly.
- Retire_valid with a non-matching id (id 99) while the commit entry is id 7 -> commit unchanged, drain_valid stays 0.
